pulse_qualifier: RTL and testbench

- Downstream consumer of the pulse-stretch stage.
- Samples a stretched, level-type pulse and measures its width in clk cycles.
- Accepts only pulses with width in [MIN_WIDTH, MAX_WIDTH] and converts each accepted pulse back into a single-cycle event.
- Counts accepted events and flags short/long pulses, giving the control logic a clean, glitch-rejected event stream.

---
 rtl/pulse_qual_pkg.sv | 15 +
 rtl/pulse_qual_sync.sv | 24 ++
 rtl/pulse_qualifier.sv | 134 +++++++++++++
 tb/tb_pulse_qualifier.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pulse_qual_pkg.sv
// rtl/pulse_qual_pkg.sv - shared state encoding and width helper for pulse_qualifier
package pulse_qual_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    LONG = 2'd2
  } pq_state_e;

  // Width needed for last_width: holds values up to MAX_WIDTH+1.
  function automatic int pq_width_w(input int max_width);
    return $clog2(max_width + 2);
  endfunction

endpackage

// File: rtl/pulse_qual_sync.sv
// rtl/pulse_qual_sync.sv - two-flop synchronizer for an asynchronous din
module pulse_qual_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pulse_qualifier.sv
// rtl/pulse_qualifier.sv - width-qualifies a stretched pulse into a one-cycle event (PULSE_QUAL_SYNC_EN adds a din synchronizer)
module pulse_qualifier
  import pulse_qual_pkg::*;
#(
  parameter int MIN_WIDTH = 4,
  parameter int MAX_WIDTH = 15,
  parameter int CNT_W     = 8,
  localparam int WW       = pq_width_w(MAX_WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             clr,
  output logic             pulse_out,
  output logic             err_short,
  output logic             err_long,
  output logic             err_sticky,
  output logic             busy,
  output logic [WW-1:0]    last_width,
  output logic [CNT_W-1:0] event_cnt
);

  localparam logic [WW-1:0]    MIN_W   = WW'(MIN_WIDTH);
  localparam logic [WW-1:0]    MAX_W   = WW'(MAX_WIDTH);
  localparam logic [WW-1:0]    ONE_W   = WW'(1);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic din_s;

`ifdef PULSE_QUAL_SYNC_EN
  pulse_qual_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (din),
    .q_o   (din_s)
  );
`else
  assign din_s = din;
`endif

  logic             din_q;
  pq_state_e        state_q, state_d;
  logic [WW-1:0]    w_cnt_q, w_cnt_d;
  logic [WW-1:0]    last_width_q, last_width_d;
  logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
  logic             pulse_q, pulse_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             sticky_q, sticky_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    w_cnt_d      = w_cnt_q;
    last_width_d = last_width_q;
    pulse_d      = 1'b0;
    short_d      = 1'b0;
    long_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_q) begin
          state_d = MEAS;
          w_cnt_d = ONE_W;
        end
      end
      MEAS: begin
        if (din_q) begin
          if (w_cnt_q < MAX_W) begin
            w_cnt_d = w_cnt_q + ONE_W;
          end else begin
            long_d  = 1'b1;
            state_d = LONG;
          end
        end else begin
          state_d = IDLE;
          if (w_cnt_q >= MIN_W) begin
            pulse_d      = 1'b1;
            last_width_d = w_cnt_q;
          end else begin
            short_d = 1'b1;
          end
        end
      end
      // Over-long pulse: ride it out silently until it drops.
      LONG: begin
        if (!din_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // clr has priority over both the increment and a new error.
    if (clr)                                event_cnt_d = '0;
    else if (pulse_d && event_cnt_q != '1)  event_cnt_d = event_cnt_q + ONE_CNT;
    else                                    event_cnt_d = event_cnt_q;

    sticky_d = clr ? 1'b0 : (sticky_q | short_d | long_d);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q        <= 1'b0;
      state_q      <= IDLE;
      w_cnt_q      <= '0;
      last_width_q <= '0;
      event_cnt_q  <= '0;
      pulse_q      <= 1'b0;
      short_q      <= 1'b0;
      long_q       <= 1'b0;
      sticky_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      din_q        <= din_s;
      state_q      <= state_d;
      w_cnt_q      <= w_cnt_d;
      last_width_q <= last_width_d;
      event_cnt_q  <= event_cnt_d;
      pulse_q      <= pulse_d;
      short_q      <= short_d;
      long_q       <= long_d;
      sticky_q     <= sticky_d;
      busy_q       <= busy_d;
    end
  end

  assign pulse_out  = pulse_q;
  assign err_short  = short_q;
  assign err_long   = long_q;
  assign err_sticky = sticky_q;
  assign busy       = busy_q;
  assign last_width = last_width_q;
  assign event_cnt  = event_cnt_q;

endmodule

// File: tb/tb_pulse_qualifier.sv
// tb/tb_pulse_qualifier.sv - randomized run-length model check of pulse_qualifier
module tb_pulse_qualifier;

  localparam int MIN_W = 4;
  localparam int MAX_W = 15;
  localparam int WW    = $clog2(MAX_W + 2);
`ifdef PULSE_QUAL_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic clr = 1'b0;

  logic          pulse_out, err_short, err_long, err_sticky, busy;
  logic [WW-1:0] last_width;
  logic [7:0]    event_cnt;

  logic          p2, s2, l2, st2, b2;
  logic [WW-1:0] lw2;
  logic [1:0]    ec2;

  always #5 clk = ~clk;

  pulse_qualifier dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .clr        (clr),
    .pulse_out  (pulse_out),
    .err_short  (err_short),
    .err_long   (err_long),
    .err_sticky (err_sticky),
    .busy       (busy),
    .last_width (last_width),
    .event_cnt  (event_cnt)
  );

  pulse_qualifier #(.CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .clr        (clr),
    .pulse_out  (p2),
    .err_short  (s2),
    .err_long   (l2),
    .err_sticky (st2),
    .busy       (b2),
    .last_width (lw2),
    .event_cnt  (ec2)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: din delayed by the pipeline depth, then judged by the length of each high run.
  int dq[$];
  int run, m_last, m_cnt, m_cnt2, m_sticky;
  int e_p, e_s, e_l, e_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic d, input logic c, input logic r);
    int x;
    @(negedge clk);
    din   = d;
    clr   = c;
    rst_n = r;
    @(posedge clk);
    cyc++;
    if (!r) begin
      dq = {};
      repeat (D) dq.push_back(0);
      run = 0; m_last = 0; m_cnt = 0; m_cnt2 = 0; m_sticky = 0;
      e_p = 0; e_s = 0; e_l = 0; e_b = 0;
    end else begin
      dq.push_back(int'(d));
      x   = dq.pop_front();
      e_p = 0; e_s = 0; e_l = 0;
      if (x != 0) begin
        run++;
        if (run == MAX_W + 1) e_l = 1;
      end else begin
        if (run >= MIN_W && run <= MAX_W) begin
          e_p    = 1;
          m_last = run;
        end else if (run >= 1 && run < MIN_W) begin
          e_s = 1;
        end
        run = 0;
      end
      e_b = (x != 0) ? 1 : 0;
      if (c) begin
        m_cnt = 0; m_cnt2 = 0; m_sticky = 0;
      end else begin
        if (e_p && m_cnt < 255) m_cnt++;
        if (e_p && m_cnt2 < 3) m_cnt2++;
        if (e_s || e_l) m_sticky = 1;
      end
    end
    #1;
    check_eq("pulse_out", 32'(pulse_out), 32'(e_p));
    check_eq("err_short", 32'(err_short), 32'(e_s));
    check_eq("err_long", 32'(err_long), 32'(e_l));
    check_eq("busy", 32'(busy), 32'(e_b));
    check_eq("err_sticky", 32'(err_sticky), 32'(m_sticky));
    check_eq("last_width", 32'(last_width), 32'(m_last));
    check_eq("event_cnt", 32'(event_cnt), 32'(m_cnt));
    check_eq("event_cnt_sat", 32'(ec2), 32'(m_cnt2));
  endtask

  task automatic pulse(input int h, input int l, input int clr_at);
    for (int i = 0; i < h; i++) step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < l; i++) step(1'b0, (i == clr_at), 1'b1);
  endtask

  initial begin
    // Reset with din held high, then a 6-cycle remainder after release.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b1);

    pulse(4, 6, -1);
    pulse(2, 6, -1);
    pulse(20, 6, -1);
    step(1'b0, 1'b1, 1'b1);
    pulse(5, 1, -1);
    pulse(5, 6, -1);
    repeat (5) pulse(5, 2, -1);
    pulse(MIN_W, 5, -1);
    pulse(MIN_W - 1, 5, -1);
    pulse(MAX_W, 5, -1);
    pulse(MAX_W + 1, 5, -1);
    pulse(1, 3, -1);
    // clr on the same edge as an accepted increment, then as an error strobe.
    pulse(6, D + 3, D);
    pulse(2, D + 3, D);
    pulse(MAX_W + 3, 2, -1);

    // Reset in the middle of a pulse.
    repeat (3) step(1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b1);

    repeat (300) begin
      int h, l, c;
      h = $urandom_range(1, 20);
      l = $urandom_range(1, 4);
      c = ($urandom_range(0, 7) == 0) ? $urandom_range(0, l - 1) : -1;
      pulse(h, l, c);
    end
    repeat (8) step(1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
